if_prefetch_queue: RTL and testbench
====================================

Name: if_prefetch_queue

Overview:
Instruction-fetch front end sitting directly upstream of the CPU decode/execute datapath. It replaces the free-running PC+IROM fetch.
- Generates word-aligned fetch PCs and drives a synchronous-read instruction ROM with 1-cycle read latency.
- Buffers returned instruction words with their PCs in a small FIFO.
- Hands instructions to decode over a valid/ready handshake.
- Accepts a redirect (branch/jump target) that flushes all buffered and in-flight fetches.

Parameters:
- DEPTH, 4: queue entries; power of two, 2..16.
- ADDR_W, 6: ROM word-address width. The ROM covers 2^(ADDR_W+2) bytes.
- RESET_PC, 32'h0000_0000: fetch PC after reset; must be word aligned.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- rom_en  out  1  ROM read request this cycle.
- rom_addr  out  ADDR_W  ROM word address, equal to fetch_pc[ADDR_W+1:2].
- rom_data  in  32  ROM read data; valid the cycle after rom_en=1.
- inst_valid  out  1  queue head holds a valid instruction.
- inst_code  out  32  head instruction word.
- inst_pc  out  32  PC of the head instruction.
- inst_ready  in  1  decode accepts the head this cycle.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch target; bits [1:0] are ignored (forced 0).
- fetch_pc  out  32  next PC to be issued.
- count  out  $clog2(DEPTH)+1  number of valid queue entries.

Behaviour:
- Reset values (rst=1 at posedge):
  - fetch_pc=RESET_PC; count=0; inst_valid=0; in-flight flag=0; rd/wr pointers=0.
  - inst_code and inst_pc = 0 when inst_valid=0.
  - While rst=1: rom_en=0.
- Issue:
  - rom_en = !rst && !redirect && (count + inflight) < DEPTH. Pops in the same cycle are not credited.
  - On issue: fetch_pc <= fetch_pc+4 (32-bit modular wrap), and inflight <= 1 tagged with the issued PC.
  - Otherwise: inflight <= 0.
- Return:
  - When inflight=1 and no redirect/rst this cycle, {rom_data, tag_pc} is written at the tail at posedge.
  - Issue-to-head latency is 2 cycles: issue in cycle N; entry visible at the head in cycle N+2 when the queue was empty. There is no combinational bypass.
- Dequeue:
  - Pop when inst_valid && inst_ready.
  - Push and pop in the same cycle leaves count unchanged.
  - Overflow is impossible by construction of the issue rule; the bench asserts count<=DEPTH.
- Ordering: strictly in PC order; no duplicated or skipped PCs between redirects.
- Redirect (priority over push, pop and issue):
  - At posedge: count<=0, pointers cleared, inflight discarded, fetch_pc<={redirect_pc[31:2],2'b00}.
  - rom_en=0 during the redirect cycle. A handshake in the redirect cycle has no effect beyond the flush.
  - First issue occurs the next cycle; first valid instruction appears 2 cycles after that.
  - Back-to-back redirects: the last one wins.
- Address wrap:
  - rom_addr uses only fetch_pc[ADDR_W+1:2], so fetch wraps within the ROM (0xFC -> 0x100 gives rom_addr 0x3F -> 0x00).
  - inst_pc carries the full 32-bit PC.
- Reset mid-operation: synchronous; everything is cleared at the next posedge regardless of redirect or handshake. An in-flight ROM word returning after reset is dropped.
- Throughput: one instruction per cycle sustained with inst_ready=1.
  - After a backpressure stall with a full queue, draining at one per cycle produces no bubble.

Test Plan:
- Reset, then inst_ready=1 constantly; ROM word k = 32'h1000_0000+k. Required: rom_en=1 from the first cycle after reset. inst_valid=1 from cycle 2 onward with no gaps. inst_pc=0,4,8,… with inst_code 0x10000000, 0x10000001, ….
- Hold inst_ready=0. Required: count reaches 4, then rom_en=0; head stays pc 0 / 0x10000000. Release inst_ready: pcs 0,4,8,12,16,20 each accepted on consecutive cycles, no bubble.
- With 3 queued entries plus one in flight, pulse redirect with redirect_pc=0x40. Required: next cycle count=0 and inst_valid=0; rom_addr=0x10 with rom_en=1. inst_pc=0x40 is valid 3 cycles after the redirect cycle; no older PC ever appears.
- Redirect with redirect_pc=0x43. Required: identical to redirect_pc=0x40, with fetch_pc=0x40.
- Redirect to 0xFC, ADDR_W=6. Required: rom_addr 0x3F then 0x00; inst_pc 0xFC then 0x100; inst_code equal to ROM words 63 then 0.
- Assert rst for one cycle mid-stream while inflight=1 and count=2. Required: next cycle count=0, inst_valid=0, fetch_pc=RESET_PC. The stale ROM word is not enqueued, and the fetch sequence restarts at pc 0.

Source files
------------

// File: rtl/if_prefetch_queue.sv
// ----------------------------------------------------------------------------
// if_prefetch_queue
//
// Instruction-fetch front end. Issues word-aligned fetch PCs to a
// synchronous-read instruction ROM (1-cycle latency), buffers the returned
// words together with their PCs in a small FIFO, and presents the oldest one
// to decode over a valid/ready handshake. A redirect flushes everything that
// is queued or in flight and restarts fetch at the new target.
//
// Ports
//   clk          single clock, all state changes on its rising edge
//   rst          synchronous reset, active high
//   rom_en       ROM read request this cycle
//   rom_addr     ROM word address (fetch_pc[ADDR_W+1:2])
//   rom_data     ROM read data, valid the cycle after rom_en
//   inst_valid   queue head holds an instruction
//   inst_code    head instruction word (0 when inst_valid=0)
//   inst_pc      head instruction PC   (0 when inst_valid=0)
//   inst_ready   decode accepts the head this cycle
//   redirect     flush and restart fetch at redirect_pc
//   redirect_pc  new fetch target, low two bits ignored
//   fetch_pc     next PC to be issued
//   count        number of valid queue entries
// ----------------------------------------------------------------------------
module if_prefetch_queue #(
   parameter int          DEPTH    = 4,
   parameter int          ADDR_W   = 6,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     rom_en,
   output logic [ADDR_W-1:0]        rom_addr,
   input  logic [31:0]              rom_data,
   output logic                     inst_valid,
   output logic [31:0]              inst_code,
   output logic [31:0]              inst_pc,
   input  logic                     inst_ready,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   output logic [31:0]              fetch_pc,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [31:0]      fetch_pc_reg;
   logic             inflight_reg;
   logic [31:0]      tag_pc_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [CNT_W-1:0] count_reg;

   logic [31:0]      code_mem [DEPTH];
   logic [31:0]      pc_mem   [DEPTH];

   logic [CNT_W:0]   occupancy;
   logic             issue;
   logic             push;
   logic             pop;
   logic [31:0]      redirect_target;

   // Masking (rather than slicing) keeps every bit of redirect_pc referenced.
   assign redirect_target = redirect_pc & ~32'h0000_0003;

   // Entries already queued plus the one word still coming back from the ROM.
   // A pop in the same cycle is deliberately not credited, which keeps the
   // issue decision independent of inst_ready.
   assign occupancy = {1'b0, count_reg} + {{CNT_W{1'b0}}, inflight_reg};
   assign issue     = !rst && !redirect && (occupancy < (CNT_W + 1)'(DEPTH));

   // Redirect flushes the returning word, so it is never pushed that cycle.
   assign push = inflight_reg && !redirect && !rst;
   assign pop  = (count_reg != '0) && inst_ready && !redirect && !rst;

   assign rom_en   = issue;
   assign rom_addr = fetch_pc_reg[ADDR_W+1:2];
   assign fetch_pc = fetch_pc_reg;
   assign count    = count_reg;

   assign inst_valid = (count_reg != '0);
   assign inst_code  = inst_valid ? code_mem[rd_ptr_reg] : 32'h0;
   assign inst_pc    = inst_valid ? pc_mem[rd_ptr_reg]   : 32'h0;

   // Control state: reset beats redirect, redirect beats push/pop/issue.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_reg <= RESET_PC;
         inflight_reg <= 1'b0;
         tag_pc_reg   <= 32'h0;
         rd_ptr_reg   <= '0;
         wr_ptr_reg   <= '0;
         count_reg    <= '0;
      end else if (redirect) begin
         fetch_pc_reg <= redirect_target;
         inflight_reg <= 1'b0;
         rd_ptr_reg   <= '0;
         wr_ptr_reg   <= '0;
         count_reg    <= '0;
      end else begin
         inflight_reg <= issue;
         if (issue) begin
            fetch_pc_reg <= fetch_pc_reg + 32'd4;
            tag_pc_reg   <= fetch_pc_reg;
         end
         // Pointers are PTR_W bits wide and DEPTH is a power of two, so
         // they wrap around the storage on their own.
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Queue storage carries no reset; only entries below count are ever read.
   always_ff @(posedge clk) begin
      if (push) begin
         code_mem[wr_ptr_reg] <= rom_data;
         pc_mem[wr_ptr_reg]   <= tag_pc_reg;
      end
   end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// ----------------------------------------------------------------------------
// tb_if_prefetch_queue
//
// Drives if_prefetch_queue against a synchronous ROM whose word k holds
// 32'h1000_0000 + k. The reference is the architectural instruction stream:
// after each reset or redirect the bench queues the PCs that must follow
// (target, target+4, ...) together with the ROM word each one maps to. A
// monitor pops one expected entry for every accepted handshake and compares.
// Directed phases cover startup, backpressure, redirects and mid-stream
// reset; a random phase follows.
// ----------------------------------------------------------------------------
module tb_if_prefetch_queue;

   localparam int          DEPTH    = 4;
   localparam int          ADDR_W   = 6;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic                   clk;
   logic                   rst;
   logic                   rom_en;
   logic [ADDR_W-1:0]      rom_addr;
   logic [31:0]            rom_data;
   logic                   inst_valid;
   logic [31:0]            inst_code;
   logic [31:0]            inst_pc;
   logic                   inst_ready;
   logic                   redirect;
   logic [31:0]            redirect_pc;
   logic [31:0]            fetch_pc;
   logic [$clog2(DEPTH):0] count;

   int checks   = 0;
   int failures = 0;
   int since_restart = 0;

   // Expected stream: {code, pc} per entry, oldest first.
   logic [63:0] sb [$];

   if_prefetch_queue #(
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rom_en      (rom_en),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .inst_valid  (inst_valid),
      .inst_code   (inst_code),
      .inst_pc     (inst_pc),
      .inst_ready  (inst_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .fetch_pc    (fetch_pc),
      .count       (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read instruction ROM, one cycle latency.
   always @(posedge clk) begin
      if (rom_en) begin
         rom_data <= 32'h1000_0000 + 32'(rom_addr);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // The ROM word a given PC must fetch: word index wraps inside the ROM.
   function automatic logic [31:0] model_code(input logic [31:0] pc);
      return 32'h1000_0000 + ((pc >> 2) & ((32'd1 << ADDR_W) - 32'd1));
   endfunction

   // Restart the expected stream at a new (word-aligned) target.
   task automatic sb_restart(input logic [31:0] target);
      logic [31:0] p;
      sb.delete();
      p = target & ~32'h3;
      for (int i = 0; i < 128; i++) begin
         sb.push_back({model_code(p), p});
         p = p + 32'd4;
      end
      since_restart = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: one line per accepted instruction, invariants every cycle.
   always @(negedge clk) begin
      logic [63:0] e;
      checks++;
      if (count > DEPTH) begin
         failures++;
         $display("FAIL count_bound actual=%0d required<=%0d", count, DEPTH);
      end
      if (!inst_valid) begin
         check("idle_code", inst_code, 32'h0);
         check("idle_pc", inst_pc, 32'h0);
      end else if (inst_ready && !redirect && !rst) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_empty actual=pc %h required=no instruction", inst_pc);
         end else begin
            e = sb.pop_front();
            $display("accept pc=%h code=%h exp_pc=%h exp_code=%h", inst_pc, inst_code, e[31:0], e[63:32]);
            check("accept_pc", inst_pc, e[31:0]);
            check("accept_code", inst_code, e[63:32]);
         end
      end
   end

   // Fill the queue with inst_ready low until count reaches want_count.
   task automatic fill_to(input int want_count);
      int n;
      inst_ready = 1'b0;
      n = 0;
      while (count != want_count && n < 40) begin
         tick();
         n++;
      end
      check("fill_count", 32'(count), 32'(want_count));
   endtask

   // Redirect with a partly filled queue and a word in flight.
   task automatic do_redirect(input logic [31:0] target);
      logic [31:0] al;
      al = target & ~32'h3;
      fill_to(3);
      redirect    = 1'b1;
      redirect_pc = target;
      inst_ready  = 1'b1;
      sb_restart(target);
      @(negedge clk);
      check("redir_rom_en", 32'(rom_en), 32'd0);
      tick();
      redirect    = 1'b0;
      redirect_pc = $urandom;
      @(negedge clk);
      check("redir_count", 32'(count), 32'd0);
      check("redir_valid", 32'(inst_valid), 32'd0);
      check("redir_rom_en1", 32'(rom_en), 32'd1);
      check("redir_rom_addr1", 32'(rom_addr), (al >> 2) & 32'h3F);
      check("redir_fetch_pc", fetch_pc, al);
      tick();
      @(negedge clk);
      check("redir_valid2", 32'(inst_valid), 32'd0);
      check("redir_rom_addr2", 32'(rom_addr), ((al + 32'd4) >> 2) & 32'h3F);
      tick();
      @(negedge clk);
      check("redir_valid3", 32'(inst_valid), 32'd1);
      check("redir_first_pc", inst_pc, al);
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst         = 1'b1;
      inst_ready  = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      sb_restart(RESET_PC);
      tick();
      tick();
      @(negedge clk);
      check("rst_rom_en", 32'(rom_en), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_valid", 32'(inst_valid), 32'd0);
      check("rst_fetch_pc", fetch_pc, RESET_PC);

      // Startup stream with decode always ready.
      tick();
      rst        = 1'b0;
      inst_ready = 1'b1;
      sb_restart(RESET_PC);
      @(negedge clk);
      check("c0_rom_en", 32'(rom_en), 32'd1);
      check("c0_rom_addr", 32'(rom_addr), 32'd0);
      check("c0_valid", 32'(inst_valid), 32'd0);
      tick();
      @(negedge clk);
      check("c1_valid", 32'(inst_valid), 32'd0);
      check("c1_fetch_pc", fetch_pc, RESET_PC + 32'd4);
      for (int i = 2; i < 12; i++) begin
         tick();
         @(negedge clk);
         check("stream_valid", 32'(inst_valid), 32'd1);
      end

      // Backpressure: queue fills, fetch stops, head holds.
      tick();
      inst_ready = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      @(negedge clk);
      check("full_count", 32'(count), DEPTH);
      check("full_rom_en", 32'(rom_en), 32'd0);
      check("full_head_pc", inst_pc, sb[0][31:0]);
      check("full_head_code", inst_code, sb[0][63:32]);
      for (int i = 0; i < 3; i++) tick();
      @(negedge clk);
      check("hold_head_pc", inst_pc, sb[0][31:0]);
      tick();
      inst_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("drain_no_bubble", 32'(inst_valid), 32'd1);
         tick();
      end

      // Redirects: plain, misaligned target, ROM-address wrap.
      do_redirect(32'h0000_0040);
      do_redirect(32'h0000_0043);
      do_redirect(32'h0000_00FC);
      for (int i = 0; i < 4; i++) tick();

      // Reset mid-stream with two queued and one word in flight.
      fill_to(2);
      rst        = 1'b1;
      inst_ready = 1'b1;
      sb_restart(RESET_PC);
      @(negedge clk);
      check("mrst_rom_en", 32'(rom_en), 32'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("mrst_count", 32'(count), 32'd0);
      check("mrst_valid", 32'(inst_valid), 32'd0);
      check("mrst_fetch_pc", fetch_pc, RESET_PC);
      check("mrst_rom_en1", 32'(rom_en), 32'd1);
      tick();
      tick();
      @(negedge clk);
      check("mrst_first_pc", inst_pc, RESET_PC);
      tick();

      // Random traffic, redirects and occasional resets.
      for (int c = 0; c < 2000; c++) begin
         inst_ready  = ($urandom_range(3) != 0);
         redirect    = 1'b0;
         rst         = 1'b0;
         redirect_pc = $urandom;
         since_restart++;
         if ($urandom_range(299) == 0) begin
            rst = 1'b1;
            sb_restart(RESET_PC);
         end else if ($urandom_range(29) == 0 || since_restart >= 100) begin
            redirect = 1'b1;
            sb_restart(redirect_pc);
         end
         tick();
      end
      redirect   = 1'b0;
      rst        = 1'b0;
      inst_ready = 1'b1;
      for (int i = 0; i < 5; i++) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
